fifo_drain: RTL and testbench
=============================

// Module: fifo_drain
// PURPOSE
//   Read-side engine for the FIFO: issues rd, captures q (registered, 1-cycle read latency) and
//   re-presents it as a valid/ready stream for downstream blocks. Absorbs rd->q latency with a
//   2-entry skid buffer to sustain 1 word/cycle. Guards against the FIFO's registered (1-cycle-late)
//   mty flag so no rd is ever issued on an empty FIFO. Sits between fifo.out and any consumer.
// PARAMETERS
//   DATA_WIDTH  128  word width; must equal the FIFO's DATA_WIDTH
//   HOLDOFF     2    cycles rd is suppressed after a rd issued with fifo_almost_mty=1; legal 1..3
// PORTS
//   CLK              in   1           single clock, all logic on posedge
//   ARST_N           in   1           asynchronous, active-low reset
//   fifo_rd          out  1           read strobe to FIFO
//   fifo_q           in   DATA_WIDTH  FIFO read data, valid the cycle after an accepted rd
//   fifo_mty         in   1           FIFO empty (registered flag)
//   fifo_almost_mty  in   1           FIFO almost empty (registered flag)
//   out_valid        out  1           stream data valid
//   out_ready        in   1           downstream ready
//   out_data         out  DATA_WIDTH  stream data
//   word_cnt         out  32          [FIFO_DRAIN_STATS_EN only] words delivered
//   stall_cnt        out  32          [FIFO_DRAIN_STATS_EN only] cycles out_valid & !out_ready
// BEHAVIOUR
//   Reset (ARST_N=0, async): fifo_rd=0, out_valid=0, out_data='0, occ=0, inflight=0, holdoff=0,
//     counters=0. Reset mid-operation discards in-flight read and buffered words.
//   State: occ (0..2 words in skid), inflight (rd issued last cycle), holdoff counter (0..HOLDOFF).
//   pop = out_valid & out_ready. Handshake: out_data/out_valid stable until pop; no combinational
//     path out_ready->out_valid; out_data is skid head; fifo_rd is registered-free combinational
//     from registered state and fifo_mty/almost_mty only (no path from out_ready permitted? no:
//     out_ready IS used via pop for full throughput; no path from fifo_q).
//   fifo_rd = !fifo_mty & (holdoff==0) & (occ + inflight - pop < 2).
//   Capture: inflight=1 -> fifo_q written into skid tail on that cycle's clock edge; inflight<=fifo_rd.
//   Holdoff: fifo_rd & fifo_almost_mty -> holdoff<=HOLDOFF; else decrement to 0. Covers the cycle in
//     which mty is still stale low after the last word leaves.
//   Skid FSM states EMPTY(occ0) / ONE(occ1) / TWO(occ2): capture&!pop +1, pop&!capture -1, both =0
//     net. Capture when TWO without pop is impossible by rd rule; assertion flags it.
//   Throughput: FIFO non-empty, out_ready=1 -> 1 word/cycle after 2-cycle fill latency
//     (rd at N, out_valid at N+2).
//   Order: words leave in exactly FIFO order; no duplication, no loss.
//   Boundaries: fifo_mty=1 -> no rd; out_ready=0 -> at most 2 words buffered then rd stops;
//     simultaneous capture and pop in TWO/ONE keep occupancy; skid pointers 1-bit, wrap freely.
// CONFIGURATION
//   `define FIFO_DRAIN_STATS_EN: adds word_cnt (+1 per pop) and stall_cnt (+1 per cycle
//     out_valid&!out_ready), both 32-bit saturating at 32'hFFFF_FFFF, reset to 0.
//   Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//   fifo_pkg: typedef enum logic[1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_t;
//     localparam SKID_DEPTH=2; localparam STATS_W=32.
//   Sub-module fifo_drain_skid: 2-entry buffer (push, pop, data, occ); fifo_drain holds rd/holdoff
//     logic and optional stats.
// TESTING
//   1. Reset, FIFO preloaded 4 words A..D, out_ready=1 -> rd cycles 0..3, out_data A,B,C,D on
//      cycles 2..5 back-to-back, out_valid=0 on cycle 6.
//   2. FIFO holds 1 word (almost_mty=1, mty stale 0 one cycle) -> exactly one rd, then fifo_rd=0
//      for HOLDOFF=2 cycles; no rd while mty=1.
//   3. 8 words, out_ready=0 -> two rd pulses, occ=2, fifo_rd=0; out_valid held with word 0 stable;
//      release out_ready -> words 0..7 in order, no gaps after restart.
//   4. out_ready toggles 1,0,1,0 over 16-word transfer -> all 16 delivered in order, no duplicates;
//      occ never exceeds 2.
//   5. ARST_N low while occ=2 and inflight=1 -> out_valid=0, fifo_rd=0 immediately (async);
//      after release, fresh 2-word burst delivered correctly.
//   6. STATS_EN: 10 pops, 3 stall cycles -> word_cnt=10, stall_cnt=3; preload 32'hFFFF_FFFF -> holds.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain_pkg
//  Description : Shared types and constants for the FIFO read-side drain engine.
//                Contents: skid-buffer state encoding, skid depth, statistics
//                counter width, occupancy helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_drain_pkg;

    // Skid occupancy states; encoding equals the number of buffered words
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int STATS_W    = 32;

    // Word count held by the skid for a given state
    function automatic logic [1:0] skid_occ(input skid_state_t s);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_drain_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain_skid
//  Description : Two-entry skid buffer. A push writes the tail, a pop retires
//                the head; both in one cycle leave occupancy unchanged.
//  Ports       : CLK, ARST_N (async active-low), push_i, pop_i, data_i,
//                data_o (head word), occ_o (0..2)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_skid
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  ARST_N,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            occ_o
);

    skid_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    // 1-bit pointers over a 2-deep store wrap naturally
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SKID_EMPTY: if (push_i)            state_d = SKID_ONE;
            SKID_ONE: begin
                if (push_i && !pop_i)          state_d = SKID_TWO;
                else if (pop_i && !push_i)     state_d = SKID_EMPTY;
            end
            SKID_TWO:   if (pop_i && !push_i)  state_d = SKID_ONE;
            default:                           state_d = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q  <= SKID_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign data_o = mem_q[rd_ptr_q];
    assign occ_o  = skid_occ(state_q);

    // The read-issue rule must never let a word arrive into a full buffer
    a_no_overflow : assert property (@(posedge CLK) disable iff (!ARST_N)
        !(push_i && !pop_i && state_q == SKID_TWO));
    a_no_underflow : assert property (@(posedge CLK) disable iff (!ARST_N)
        !(pop_i && state_q == SKID_EMPTY));

endmodule
`default_nettype wire

// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain
//  Description : FIFO read-side engine. Issues fifo_rd, captures fifo_q one
//                cycle later into a 2-entry skid and presents it as a
//                valid/ready stream at one word per cycle.
//  Ports       : CLK, ARST_N (async active-low), fifo_rd, fifo_q, fifo_mty,
//                fifo_almost_mty, out_valid, out_ready, out_data,
//                word_cnt / stall_cnt (only with FIFO_DRAIN_STATS_EN)
//  Config      : `define FIFO_DRAIN_STATS_EN adds saturating 32-bit counters
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int HOLDOFF    = 2
) (
    input  logic                  CLK,
    input  logic                  ARST_N,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_mty,
    input  logic                  fifo_almost_mty,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [STATS_W-1:0]    word_cnt,
    output logic [STATS_W-1:0]    stall_cnt
`endif
);

    logic       inflight_q, inflight_d;
    logic [1:0] holdoff_q,  holdoff_d;
    logic [1:0] occ;
    logic       pop;
    logic [2:0] committed;

    fifo_drain_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .CLK    (CLK),
        .ARST_N (ARST_N),
        .push_i (inflight_q),
        .pop_i  (pop),
        .data_i (fifo_q),
        .data_o (out_data),
        .occ_o  (occ)
    );

    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & out_ready;

    // Words buffered plus the one in flight, before this cycle's pop
    assign committed = {1'b0, occ} + {2'b00, inflight_q};

    // A pop this cycle frees a slot, which keeps 1 word/cycle under full flow.
    // ARST_N gating forces the strobe low the instant reset asserts.
    always_comb begin
        fifo_rd = ARST_N & !fifo_mty & (holdoff_q == 2'd0)
                & (committed < (3'd2 + {2'b00, pop}));
    end

    // Reading the last word leaves mty low for one more cycle; the holdoff
    // window keeps rd off until the flag has caught up.
    always_comb begin
        inflight_d = fifo_rd;
        holdoff_d  = holdoff_q;
        if (fifo_rd && fifo_almost_mty) begin
            holdoff_d = 2'(HOLDOFF);
        end else if (holdoff_q != 2'd0) begin
            holdoff_d = holdoff_q - 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            inflight_q <= 1'b0;
            holdoff_q  <= 2'd0;
        end else begin
            inflight_q <= inflight_d;
            holdoff_q  <= holdoff_d;
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [STATS_W-1:0] word_cnt_q, stall_cnt_q;

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && (word_cnt_q != '1)) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_drain
//  Description : Self-checking bench for fifo_drain. A queue-based FIFO model
//                (mty flag lagging one cycle, almost_mty current) feeds the
//                DUT; a skid-queue reference and an in-order scoreboard check
//                the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain;

    localparam int DW      = 128;
    localparam int HOLDOFF = 2;

    logic          CLK = 1'b0;
    logic          ARST_N;
    logic          fifo_rd;
    logic [DW-1:0] fifo_q;
    logic          fifo_mty;
    logic          fifo_almost_mty;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0]   word_cnt;
    logic [31:0]   stall_cnt;
`endif

    fifo_drain #(
        .DATA_WIDTH (DW),
        .HOLDOFF    (HOLDOFF)
    ) dut (
        .CLK             (CLK),
        .ARST_N          (ARST_N),
        .fifo_rd         (fifo_rd),
        .fifo_q          (fifo_q),
        .fifo_mty        (fifo_mty),
        .fifo_almost_mty (fifo_almost_mty),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .word_cnt        (word_cnt),
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] fq[$];    // FIFO contents
    logic [DW-1:0] rdq[$];   // words read from the FIFO, in order, not yet delivered
    logic [DW-1:0] sq[$];    // reference skid contents
    bit            inflight_m;
    int            hold_m;
    bit            mty_reg;
    logic [DW-1:0] nxt_q;
    bit            nxt_valid;
    int            n_pop, n_stall, n_rd;
    bit            rec_rd, rec_valid;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load(input int n);
        for (int i = 0; i < n; i++) fq.push_back(rand_word());
    endtask

    // One clock cycle: drive FIFO/stream inputs, check, advance the models
    task automatic step(input bit rdy, input int wr_pct);
        int sz;
        bit pop_m, exp_rd;
        @(negedge CLK);
        fifo_q          = nxt_valid ? nxt_q : rand_word();
        fifo_mty        = mty_reg;
        fifo_almost_mty = (fq.size() <= 1);
        out_ready       = rdy;
        #1;
        sz = sq.size();
        check("valid", out_valid, sz != 0);
        if (sz != 0) check("data", out_data, sq[0]);
        pop_m  = (sz != 0) && rdy;
        exp_rd = !fifo_mty && (hold_m == 0) && (sz + int'(inflight_m) < 2 + int'(pop_m));
        check("rd", fifo_rd, exp_rd);
        if (fifo_rd) check("rd_not_empty", fq.size() != 0, 1'b1);
        if (out_valid && out_ready) begin
            n_pop++;
            if (rdq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL order: delivered %0h with no word outstanding", out_data);
            end else begin
                check("order", out_data, rdq.pop_front());
            end
        end
        if (out_valid && !out_ready) n_stall++;
        rec_rd    = fifo_rd;
        rec_valid = out_valid;
        if (fifo_rd) n_rd++;
        // Advance reference models
        if (pop_m) void'(sq.pop_front());
        if (inflight_m) sq.push_back(fifo_q);
        if (fifo_rd && fifo_almost_mty) hold_m = HOLDOFF;
        else if (hold_m > 0)            hold_m--;
        mty_reg = (fq.size() == 0);
        if (fifo_rd && fq.size() != 0) begin
            nxt_q     = fq.pop_front();
            rdq.push_back(nxt_q);
            nxt_valid = 1'b1;
        end else begin
            nxt_valid = 1'b0;
        end
        inflight_m = fifo_rd;
        if (int'($urandom_range(99)) < wr_pct) fq.push_back(rand_word());
    endtask

    task automatic do_reset();
        @(negedge CLK);
        fifo_mty        = 1'b0;
        fifo_almost_mty = 1'b0;
        out_ready       = 1'b1;
        ARST_N          = 1'b0;
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_rd", fifo_rd, 1'b0);
        check("rst_data", out_data, '0);
        sq.delete();
        rdq.delete();
        inflight_m = 1'b0;
        hold_m     = 0;
        nxt_valid  = 1'b0;
        n_pop      = 0;
        n_stall    = 0;
        @(posedge CLK);
        @(posedge CLK);
        #1 ARST_N = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(1'b1, 0);
    endtask

    initial begin
        logic [7:0] rd_bits, v_bits;
        int pops0, stalls0;
        ARST_N = 1'b1;
        fifo_q = '0; fifo_mty = 1'b1; fifo_almost_mty = 1'b1; out_ready = 1'b0;
        mty_reg = 1'b1; inflight_m = 1'b0; hold_m = 0; nxt_valid = 1'b0;
        n_pop = 0; n_stall = 0; n_rd = 0;

        // Test 1: four words preloaded, consumer always ready
        load(4);
        mty_reg = 1'b0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 0);
            rd_bits[c] = rec_rd;
            v_bits[c]  = rec_valid;
        end
        check("t1_rd_pattern", rd_bits, 8'b0000_1111);
        check("t1_valid_pattern", v_bits, 8'b0011_1100);
        check("t1_pops", n_pop, 4);

        // Test 2: single word, holdoff masks the stale empty flag
        drain();
        load(1);
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 0);
            rd_bits[c] = rec_rd;
        end
        check("t2_rd_pattern", rd_bits, 8'b0000_0010);

        // Test 3: eight words with the consumer stalled, then released
        drain();
        load(8);
        n_rd = 0; n_pop = 0;
        for (int c = 0; c < 8; c++) step(1'b0, 0);
        check("t3_rd_while_stalled", n_rd, 2);
        check("t3_valid_held", out_valid, 1'b1);
        for (int c = 0; c < 14; c++) step(1'b1, 0);
        check("t3_pops", n_pop, 8);

        // Test 4: sixteen words, ready alternating
        drain();
        load(16);
        n_pop = 0;
        for (int c = 0; c < 48; c++) step(c[0] == 1'b0, 0);
        check("t4_pops", n_pop, 16);

        // Test 5: reset mid-stream, then a fresh two-word burst
        drain();
        load(8);
        for (int c = 0; c < 4; c++) step(1'b1, 0);
        do_reset();
        fq.delete();
        mty_reg = 1'b1;
        step(1'b1, 0);
        step(1'b1, 0);
        load(2);
        n_pop = 0;
        for (int c = 0; c < 10; c++) step(1'b1, 0);
        check("t5_pops", n_pop, 2);

        // Randomised traffic and backpressure from a fresh reset
        do_reset();
        pops0 = n_pop; stalls0 = n_stall;
        for (int c = 0; c < 3000; c++) step($urandom_range(99) < 60, 45);
        for (int c = 0; c < 200 && (fq.size() != 0 || sq.size() != 0 || inflight_m); c++) step(1'b1, 0);
        drain();
        check("rand_all_delivered", rdq.size(), 0);
        check("rand_fifo_empty", fq.size(), 0);
`ifdef FIFO_DRAIN_STATS_EN
        check("stats_word_cnt", word_cnt, n_pop - pops0);
        check("stats_stall_cnt", stall_cnt, n_stall - stalls0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
